// File: rtl/sample_pack.sv
// sample_pack: serial-to-parallel front end for the unrolled mixer/FIR datapath.
// Collects UNR consecutive ADC samples into one lane vector. The vector is
// presented together with a one-cycle EN strobe. An acquisition of FRAMELEN
// samples is framed so that its first sample always lands in lane 0.
//
// Ports:
//   CLK      system clock, rising edge
//   RST      synchronous active-high reset
//   start    begins an acquisition when seen in IDLE
//   s_data   ADC sample (unsigned, DWIDTH bits)
//   s_valid  s_data valid this cycle
//   dout     lane vector, dout[0] holds the earliest sample
//   EN       one-cycle strobe: dout holds a new word
//   busy     high while filling
//   done     one-cycle pulse with the final word of an acquisition
//   wcnt     words emitted in the current / most recent acquisition
module sample_pack #(
    parameter int DWIDTH   = 14,
    parameter int UNR      = 4,
    parameter int FRAMELEN = 1024,
    parameter int WCW      = $clog2(FRAMELEN/UNR)+1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic [DWIDTH-1:0] dout [UNR],
    output logic              EN,
    output logic              busy,
    output logic              done,
    output logic [WCW-1:0]    wcnt
);

    localparam int LW  = $clog2(UNR);
    localparam int SCW = $clog2(FRAMELEN)+1;
    localparam logic [LW-1:0]  LLAST = LW'(UNR-1);
    localparam logic [SCW-1:0] SLAST = SCW'(FRAMELEN-1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state;
    logic [LW-1:0]     lidx;
    logic [SCW-1:0]    scnt;
    // Only lanes 0..UNR-2 are staged; the last lane comes straight from s_data.
    logic [DWIDTH-1:0] stage [UNR-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            busy  <= 1'b0;
            EN    <= 1'b0;
            done  <= 1'b0;
            wcnt  <= '0;
            lidx  <= '0;
            scnt  <= '0;
            for (int unsigned i = 0; i < UNR; i++)
                dout[LW'(i)] <= '0;
            for (int unsigned i = 0; i < UNR-1; i++)
                stage[LW'(i)] <= '0;
        end else begin
            EN   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        busy  <= 1'b1;
                        lidx  <= '0;
                        scnt  <= '0;
                        wcnt  <= '0;
                    end
                end
                FILL: begin
                    if (s_valid) begin
                        scnt <= scnt + 1'b1;
                        if (lidx == LLAST) begin
                            for (int unsigned i = 0; i < UNR-1; i++)
                                dout[LW'(i)] <= stage[LW'(i)];
                            dout[LLAST] <= s_data;
                            EN   <= 1'b1;
                            wcnt <= wcnt + 1'b1;
                            lidx <= '0;
                            // FRAMELEN is a multiple of UNR, so the last sample
                            // always completes a word.
                            if (scnt == SLAST) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            stage[lidx] <= s_data;
                            lidx        <= lidx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sample_pack.md
# sample_pack

Serial-to-parallel front end for the unrolled mixer/FIR datapath. It accepts one ADC sample per accepted cycle, groups UNR consecutive samples into one lane vector, and presents the vector with a single-cycle EN strobe. The lane vector and EN drive the datapath's `din[UNR]` and `EN` inputs directly. The block also frames an acquisition of FRAMELEN samples, so that the first sample of every acquisition lands in lane 0 and the sine phase stays aligned.

## Interface
- DWIDTH, 14: sample width in bits.
- UNR, 4: unroll factor, i.e. samples per output word. Must be ≥2.
- FRAMELEN, 1024: samples per acquisition. Must be a non-zero multiple of UNR.
- WCW, $clog2(FRAMELEN/UNR)+1: width of the word counter.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  begins an acquisition when sampled high in IDLE.
- s_data  input  DWIDTH  ADC sample, unsigned.
- s_valid  input  1  s_data is valid this cycle.
- dout  output  [DWIDTH-1:0] x UNR (unpacked `dout [UNR]`)  packed lane vector. Lane 0 holds the earliest sample.
- EN  output  1  one-cycle strobe: dout holds a new word.
- busy  output  1  high while in FILL.
- done  output  1  one-cycle pulse on the final word of an acquisition.
- wcnt  output  WCW  number of words emitted in the current or most recent acquisition.

## Operation
State machine:
- **IDLE**
  - busy=0; s_valid is ignored.
  - start=1 → FILL. In the same cycle: lane index=0, sample count=0, wcnt=0.
- **FILL**
  - busy=1.
  - Each cycle with s_valid=1 writes s_data into staging lane `lidx` and increments `lidx` and the sample count.
  - When `lidx`=UNR-1 and s_valid=1, the word is complete:
    - staging lanes 0..UNR-2 plus the current s_data are registered into dout;
    - EN=1 in the next cycle;
    - wcnt increments;
    - `lidx` wraps to 0.
  - When the completed word holds sample FRAMELEN-1 → DONE.
  - s_valid=0 cycles (gaps) hold all state; lanes never shift on a gap.
  - start is ignored while in FILL.
- **DONE**
  - Lasts one cycle, then returns to IDLE.
  - s_valid and start are ignored in DONE.

Datapath rules:
- dout is held between EN strobes. It changes only on the edge that raises EN.
- There is no partial flush: an incomplete word is never emitted.
- wcnt holds its final value through IDLE until the next start clears it.

Boundary conditions:
- Reset mid-FILL: the partial word is discarded and no EN is produced. The next start realigns to lane 0.
- start and s_valid in the same IDLE cycle: that sample is not captured. Capture begins the cycle after FILL is entered.
- Back-to-back acquisitions: start may be asserted the cycle after DONE; the earliest re-entry to FILL is 2 cycles after the final EN.

## Timing
Reset values (on a clock edge with RST=1):
- state=IDLE, busy=0, EN=0, done=0, wcnt=0, dout lanes all 0, lidx=0, sample count=0.
- RST has priority over every other input.

Latency and rates:
- Latency: the UNR-th sample of a word is accepted at edge N; EN and the new dout are visible in cycle N+1, held for exactly one cycle (EN).
- Peak rate: with s_valid held high, EN pulses once every UNR cycles.
- The last word's EN and done are high in the same cycle. busy falls in that cycle, because state=DONE then.
- The state is DONE during the EN/done cycle and IDLE in the following cycle.

Arithmetic:
- No arithmetic is applied to samples; they pass through bit-exact.
- The sample counter is $clog2(FRAMELEN)+1 bits and never wraps within an acquisition.

## Test plan
- **Basic pack** (UNR=4, FRAMELEN=8):
  - Stimulus: start, then samples 1..8 on consecutive cycles.
  - Response: EN two times, with dout={1,2,3,4} and then dout={5,6,7,8}.
  - EN cycles are 4 apart; done coincides with the second EN; wcnt=2.
- **Gapped input:**
  - Stimulus: samples 10,11,12,13 with s_valid low for 3 cycles between each pair.
  - Response: exactly one EN, one cycle after 13 is accepted; dout={10,11,12,13}; dout unchanged before that.
- **IDLE / DONE ignore:**
  - Stimulus: s_valid=1 with data 0x3FFF before start; after done, 4 more samples.
  - Response: no EN, wcnt stays 2, dout keeps {5,6,7,8}.
- **Reset mid-frame:**
  - Stimulus: start, samples 1,2, RST for 1 cycle, start, samples 7,8,9,10.
  - Response: no EN before RST; all outputs 0 after reset; then EN with dout={7,8,9,10}.
- **start while busy:**
  - Stimulus: assert start again after sample 2 of a frame.
  - Response: no realignment; the first word still equals samples 1..4.
- **Full frame at default parameters:**
  - Stimulus: FRAMELEN=1024, continuous ramp 0..1023.
  - Response: 256 EN pulses; word k = {4k, 4k+1, 4k+2, 4k+3}; done on the 256th EN; wcnt=256.
